timer_scheduler: RTL

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler_if.sv | 32 +++
 rtl/timer_scheduler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if: bundles the requester side (req/period/done/grant) and
// the flex-counter side (cnt_*) of the shared timer scheduler.
//   master : requesters + external counter (drive req, periodN, cnt_rollover_flag)
//   slave  : the scheduler (drives grant, done, busy, cnt_clear, cnt_enable,
//            cnt_rollover_val)
interface timer_scheduler_if;
  localparam int unsigned N_REQ    = 4;
  localparam int unsigned PERIOD_W = 16;

  logic [N_REQ-1:0]    req;
  logic [PERIOD_W-1:0] period0;
  logic [PERIOD_W-1:0] period1;
  logic [PERIOD_W-1:0] period2;
  logic [PERIOD_W-1:0] period3;
  logic                cnt_rollover_flag;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic                busy;
  logic                cnt_clear;
  logic                cnt_enable;
  logic [PERIOD_W-1:0] cnt_rollover_val;

  modport master (
    output req, period0, period1, period2, period3, cnt_rollover_flag,
    input  grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
  );

  modport slave (
    input  req, period0, period1, period2, period3, cnt_rollover_flag,
    output grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
  );
endinterface

// File: rtl/timer_scheduler.sv
// timer_scheduler: lends one external 16-bit flex counter to four requesters
// in round-robin order. The owner's period becomes the counter rollover value;
// when the counter flags rollover the owner gets a one-cycle done pulse.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - timer_scheduler_if.slave (req/periodN/cnt_rollover_flag in,
//          grant/done/busy/cnt_clear/cnt_enable/cnt_rollover_val out)
module timer_scheduler (
  input logic              clk,
  input logic              rst,
  timer_scheduler_if.slave bus
);
  localparam int unsigned N_REQ    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned PERIOD_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    owner_idx;
  logic [N_REQ-1:0]    grant_q;
  logic [N_REQ-1:0]    done_q;
  logic                busy_q;
  logic                cnt_clear_q;
  logic [PERIOD_W-1:0] rollover_q;

  logic [PERIOD_W-1:0] period_arr [N_REQ];
  logic [PERIOD_W-1:0] owner_period;
  logic                owner_req;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic                win_valid;

  assign period_arr[0] = bus.period0;
  assign period_arr[1] = bus.period1;
  assign period_arr[2] = bus.period2;
  assign period_arr[3] = bus.period3;

  assign owner_period = period_arr[owner_idx];
  assign owner_req    = bus.req[owner_idx];

  // Round-robin pick: first asserted request scanning upward from rr_ptr.
  always_comb begin
    win_idx   = rr_ptr;
    win_valid = 1'b0;
    cand_idx  = rr_ptr;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand_idx = rr_ptr + IDX_W'(k);
      if (!win_valid && bus.req[cand_idx]) begin
        win_idx   = cand_idx;
        win_valid = 1'b1;
      end
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner_idx   <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      cnt_clear_q <= 1'b1;
      rollover_q  <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state       <= ST_LOAD;
            owner_idx   <= win_idx;
            grant_q     <= N_REQ'(1) << win_idx;
            rr_ptr      <= win_idx + IDX_W'(1);
            busy_q      <= 1'b1;
            cnt_clear_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          // The period is latched even when the owner aborts in this cycle.
          rollover_q <= owner_period;
          if (!owner_req) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            cnt_clear_q <= 1'b1;
          end else if (owner_period == '0) begin
            state       <= ST_DONE;
            done_q      <= grant_q;
            cnt_clear_q <= 1'b1;
          end else begin
            state       <= ST_RUN;
            cnt_clear_q <= 1'b0;
          end
        end
        ST_RUN: begin
          // Abort wins over a simultaneous rollover: the owner no longer wants done.
          if (!owner_req) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            cnt_clear_q <= 1'b1;
          end else if (bus.cnt_rollover_flag) begin
            state       <= ST_DONE;
            done_q      <= grant_q;
            cnt_clear_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          grant_q     <= '0;
          busy_q      <= 1'b0;
          cnt_clear_q <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          grant_q     <= '0;
          busy_q      <= 1'b0;
          cnt_clear_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.grant            = grant_q;
  assign bus.done             = done_q;
  assign bus.busy             = busy_q;
  assign bus.cnt_clear        = cnt_clear_q;
  assign bus.cnt_rollover_val = rollover_q;
  // Enable must drop in the same cycle the counter flags rollover, so it
  // follows the flag combinationally.
  assign bus.cnt_enable       = (state == ST_RUN) && !bus.cnt_rollover_flag;

endmodule
